// File: rtl/wb_stage_if.sv
// rtl/wb_stage_if.sv - instruction-result handshake, load response and register-file write bundle
interface wb_stage_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  localparam int OFF_W = $clog2(DATA_WIDTH / 8);

  logic                      in_valid_i;
  logic                      in_ready_o;
  logic [1:0]                result_src_i;
  logic [DATA_WIDTH-1:0]     alu_result_i;
  logic [DATA_WIDTH-1:0]     csr_rdata_i;
  logic [DATA_WIDTH-1:0]     pc_i;
  logic [REG_ADDR_WIDTH-1:0] rd_addr_i;
  logic                      rd_we_i;
  logic [2:0]                load_funct3_i;
  logic [OFF_W-1:0]          byte_off_i;
  logic                      mem_rvalid_i;
  logic [DATA_WIDTH-1:0]     mem_rdata_i;
  logic                      rf_we_o;
  logic [REG_ADDR_WIDTH-1:0] rf_waddr_o;
  logic [DATA_WIDTH-1:0]     rf_wdata_o;

  modport master (
    output in_valid_i, result_src_i, alu_result_i, csr_rdata_i, pc_i,
    output rd_addr_i, rd_we_i, load_funct3_i, byte_off_i,
    output mem_rvalid_i, mem_rdata_i,
    input  in_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o
  );

  modport slave (
    input  in_valid_i, result_src_i, alu_result_i, csr_rdata_i, pc_i,
    input  rd_addr_i, rd_we_i, load_funct3_i, byte_off_i,
    input  mem_rvalid_i, mem_rdata_i,
    output in_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o
  );
endinterface

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - write-back stage: result select, load formatting, register-file write, retire count
module wb_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int PC_INC         = 4,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  wb_stage_if.slave            bus,
  output logic                 busy_o,
  output logic [CNT_WIDTH-1:0] retired_o
);
  localparam int OFF_W = $clog2(DATA_WIDTH / 8);

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  state_t                    r_state;
  state_t                    w_next_state;

  logic [REG_ADDR_WIDTH-1:0] r_ld_rd_addr;
  logic                      r_ld_rd_we;
  logic [2:0]                r_ld_funct3;
  logic [OFF_W-1:0]          r_ld_off;

  logic                      r_rf_we;
  logic [REG_ADDR_WIDTH-1:0] r_rf_waddr;
  logic [DATA_WIDTH-1:0]     r_rf_wdata;
  logic [CNT_WIDTH-1:0]      r_retired;

  logic                      w_accept;
  logic                      w_accept_load;
  logic                      w_accept_now;
  logic                      w_load_done;
  logic                      w_now_we;
  logic                      w_load_we;
  logic [DATA_WIDTH-1:0]     w_sel_result;
  logic [DATA_WIDTH-1:0]     w_load_result;
  logic [OFF_W-1:0]          w_off_h;
  logic [OFF_W-1:0]          w_off_w;
  logic [DATA_WIDTH-1:0]     w_sh_b;
  logic [DATA_WIDTH-1:0]     w_sh_h;
  logic [DATA_WIDTH-1:0]     w_sh_w;

  assign w_accept      = bus.in_valid_i && (r_state == IDLE);
  assign w_accept_load = w_accept && (bus.result_src_i == 2'b01);
  assign w_accept_now  = w_accept && (bus.result_src_i != 2'b01);
  // mem_rvalid_i only has meaning while a load is outstanding
  assign w_load_done   = (r_state == WAIT_MEM) && bus.mem_rvalid_i;
  // writes to x0 are suppressed, but the transfer still retires
  assign w_now_we      = bus.rd_we_i && (bus.rd_addr_i != '0);
  assign w_load_we     = r_ld_rd_we && (r_ld_rd_addr != '0);

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state: a load parks the stage until its response arrives
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:     if (w_accept_load) w_next_state = WAIT_MEM;
      WAIT_MEM: if (bus.mem_rvalid_i) w_next_state = IDLE;
      default:  w_next_state = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    bus.in_ready_o = (r_state == IDLE);
    busy_o         = (r_state == WAIT_MEM);
  end

  // Non-load result select; the link value wraps naturally at DATA_WIDTH
  always_comb begin
    w_sel_result = bus.alu_result_i;
    case (bus.result_src_i)
      2'b10:   w_sel_result = bus.pc_i + DATA_WIDTH'(PC_INC);
      2'b11:   w_sel_result = bus.csr_rdata_i;
      default: w_sel_result = bus.alu_result_i;
    endcase
  end

  // Load formatting: shift the addressed lane down, then extend; halfword/word offsets are aligned down
  always_comb begin
    w_off_h       = r_ld_off & ~OFF_W'(1);
    w_off_w       = r_ld_off & ~OFF_W'(3);
    w_sh_b        = bus.mem_rdata_i >> {r_ld_off, 3'b000};
    w_sh_h        = bus.mem_rdata_i >> {w_off_h, 3'b000};
    w_sh_w        = bus.mem_rdata_i >> {w_off_w, 3'b000};
    w_load_result = bus.mem_rdata_i;
    case (r_ld_funct3)
      3'b000:  w_load_result = DATA_WIDTH'($signed(w_sh_b[7:0]));
      3'b100:  w_load_result = DATA_WIDTH'(w_sh_b[7:0]);
      3'b001:  w_load_result = DATA_WIDTH'($signed(w_sh_h[15:0]));
      3'b101:  w_load_result = DATA_WIDTH'(w_sh_h[15:0]);
      3'b010:  w_load_result = DATA_WIDTH'($signed(w_sh_w[31:0]));
      3'b110:  w_load_result = (DATA_WIDTH == 64) ? DATA_WIDTH'(w_sh_w[31:0]) : bus.mem_rdata_i;
      default: w_load_result = bus.mem_rdata_i;
    endcase
  end

  // Load context capture, register-file write port and retire counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ld_rd_addr <= '0;
      r_ld_rd_we   <= 1'b0;
      r_ld_funct3  <= '0;
      r_ld_off     <= '0;
      r_rf_we      <= 1'b0;
      r_rf_waddr   <= '0;
      r_rf_wdata   <= '0;
      r_retired    <= '0;
    end else begin
      r_rf_we <= 1'b0;
      if (w_accept_load) begin
        r_ld_rd_addr <= bus.rd_addr_i;
        r_ld_rd_we   <= bus.rd_we_i;
        r_ld_funct3  <= bus.load_funct3_i;
        r_ld_off     <= bus.byte_off_i;
      end
      if (w_accept_now) begin
        r_rf_we   <= w_now_we;
        r_retired <= r_retired + CNT_WIDTH'(1);
        if (w_now_we) begin
          r_rf_waddr <= bus.rd_addr_i;
          r_rf_wdata <= w_sel_result;
        end
      end else if (w_load_done) begin
        r_rf_we   <= w_load_we;
        r_retired <= r_retired + CNT_WIDTH'(1);
        if (w_load_we) begin
          r_rf_waddr <= r_ld_rd_addr;
          r_rf_wdata <= w_load_result;
        end
      end
    end
  end

  assign bus.rf_we_o    = r_rf_we;
  assign bus.rf_waddr_o = r_rf_waddr;
  assign bus.rf_wdata_o = r_rf_wdata;
  assign retired_o      = r_retired;
endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - scoreboard bench for wb_stage (32-bit main instance, 64-bit load/wrap instance)
module tb_wb_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_stage_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) bus ();
  wb_stage_if #(.DATA_WIDTH(64), .REG_ADDR_WIDTH(5)) bus64 ();
  logic        busy;
  logic [31:0] retired;
  logic        busy64;
  logic [1:0]  ret64;

  wb_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .PC_INC(4), .CNT_WIDTH(32)) u_dut (
    .clk_i(clk), .rst_i(rst), .bus(bus), .busy_o(busy), .retired_o(retired));
  wb_stage #(.DATA_WIDTH(64), .REG_ADDR_WIDTH(5), .PC_INC(4), .CNT_WIDTH(2)) u_dut64 (
    .clk_i(clk), .rst_i(rst), .bus(bus64), .busy_o(busy64), .retired_o(ret64));

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [31:0] m_ret = '0;
  logic [31:0] last_d = '0;
  logic [4:0]  p_rd;
  logic        p_we;
  logic [2:0]  p_f3;
  logic [1:0]  p_off;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] fmt32(input logic [31:0] d, input logic [2:0] f3, input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[8*off +: 8];
    h = off[1] ? d[31:16] : d[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      default: return d;
    endcase
  endfunction

  // Drive one transfer at a negedge; non-load results are scored immediately, loads are parked
  task automatic issue(input logic [1:0] src, input logic [4:0] rd, input logic we, input logic [31:0] v,
                       input logic [2:0] f3, input logic [1:0] off, input logic mv);
    exp_t e;
    check("in_ready_issue", bus.in_ready_o, 1);
    bus.in_valid_i    = 1'b1;
    bus.result_src_i  = src;
    bus.rd_addr_i     = rd;
    bus.rd_we_i       = we;
    bus.alu_result_i  = $urandom;
    bus.csr_rdata_i   = $urandom;
    bus.pc_i          = $urandom;
    case (src)
      2'b00: bus.alu_result_i = v;
      2'b10: bus.pc_i = v;
      2'b11: bus.csr_rdata_i = v;
      default: ;
    endcase
    bus.load_funct3_i = f3;
    bus.byte_off_i    = off;
    bus.mem_rvalid_i  = mv;
    bus.mem_rdata_i   = $urandom;
    if (src != 2'b01) begin
      e.we   = we && (rd != 5'd0);
      e.addr = rd;
      e.data = (src == 2'b10) ? v + 32'd4 : v;
      e.due  = cyc + 1;
      sb.push_back(e);
    end else begin
      p_rd = rd; p_we = we; p_f3 = f3; p_off = off;
    end
    @(negedge clk);
    bus.in_valid_i   = 1'b0;
    bus.mem_rvalid_i = 1'b0;
  endtask

  task automatic mem_resp(input logic [31:0] d, input int waits);
    exp_t e;
    for (int i = 0; i < waits; i++) begin
      check("busy_wait", busy, 1);
      check("in_ready_wait", bus.in_ready_o, 0);
      @(negedge clk);
    end
    check("in_ready_rsp", bus.in_ready_o, 0);
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = d;
    e.we   = p_we && (p_rd != 5'd0);
    e.addr = p_rd;
    e.data = fmt32(d, p_f3, p_off);
    e.due  = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    bus.mem_rvalid_i = 1'b0;
    check("in_ready_back", bus.in_ready_o, 1);
    check("busy_back", busy, 0);
  endtask

  task automatic do_reset(input logic offer);
    rst               = 1'b1;
    bus.in_valid_i    = offer;
    bus.result_src_i  = 2'b00;
    bus.rd_addr_i     = 5'd7;
    bus.rd_we_i       = 1'b1;
    bus.alu_result_i  = 32'hAAAA_5555;
    m_ret             = '0;
    last_d            = '0;
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    check("rst_rf_we", bus.rf_we_o, 0);
    check("rst_waddr", bus.rf_waddr_o, 0);
    check("rst_wdata", bus.rf_wdata_o, 0);
    check("rst_retired", retired, 0);
    check("rst_in_ready", bus.in_ready_o, 1);
    check("rst_busy", busy, 0);
    rst = 1'b0;
  endtask

  task automatic load64(input string tag, input logic [2:0] f3, input logic [2:0] off,
                        input logic [63:0] d, input logic [63:0] e);
    bus64.in_valid_i    = 1'b1;
    bus64.result_src_i  = 2'b01;
    bus64.rd_addr_i     = 5'd3;
    bus64.rd_we_i       = 1'b1;
    bus64.load_funct3_i = f3;
    bus64.byte_off_i    = off;
    @(negedge clk);
    bus64.in_valid_i = 1'b0;
    check({tag, "_busy"}, busy64, 1);
    bus64.mem_rvalid_i = 1'b1;
    bus64.mem_rdata_i  = d;
    @(negedge clk);
    bus64.mem_rvalid_i = 1'b0;
    check({tag, "_we"}, bus64.rf_we_o, 1);
    check(tag, bus64.rf_wdata_o, e);
  endtask

  // Monitor: every completed transfer pops one expectation
  always begin
    @(posedge clk);
    #1;
    if (!rst && (bus.rf_we_o || retired != m_ret)) begin
      if (sb.size() == 0) begin
        check("spurious_we", bus.rf_we_o, 0);
        check("spurious_retire", retired, m_ret);
      end else begin
        mon_e = sb.pop_front();
        m_ret = m_ret + 32'd1;
        check("sb_rf_we", bus.rf_we_o, mon_e.we);
        check("sb_retired", retired, m_ret);
        check("sb_latency", cyc, mon_e.due);
        if (mon_e.we) begin
          check("sb_waddr", bus.rf_waddr_o, mon_e.addr);
          check("sb_wdata", bus.rf_wdata_o, mon_e.data);
          last_d = mon_e.data;
        end else begin
          check("sb_wdata_hold", bus.rf_wdata_o, last_d);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    logic [2:0] lf3 [6];
    logic [1:0] src;
    int         r;
    lf3 = '{3'b001, 3'b010, 3'b110, 3'b011, 3'b111, 3'b100};
    bus.in_valid_i = 0; bus.result_src_i = 0; bus.alu_result_i = 0; bus.csr_rdata_i = 0;
    bus.pc_i = 0; bus.rd_addr_i = 0; bus.rd_we_i = 0; bus.load_funct3_i = 0; bus.byte_off_i = 0;
    bus.mem_rvalid_i = 0; bus.mem_rdata_i = 0;
    bus64.in_valid_i = 0; bus64.result_src_i = 0; bus64.alu_result_i = 0; bus64.csr_rdata_i = 0;
    bus64.pc_i = 0; bus64.rd_addr_i = 0; bus64.rd_we_i = 0; bus64.load_funct3_i = 0; bus64.byte_off_i = 0;
    bus64.mem_rvalid_i = 0; bus64.mem_rdata_i = 0;
    @(negedge clk);
    do_reset(1'b0);

    issue(2'b00, 5'd5, 1'b1, 32'h1234_5678, 3'b0, 2'd0, 1'b0);
    check("alu_we", bus.rf_we_o, 1);
    check("alu_waddr", bus.rf_waddr_o, 5);
    check("alu_wdata", bus.rf_wdata_o, 32'h1234_5678);
    check("alu_retired", retired, 1);
    issue(2'b10, 5'd1, 1'b1, 32'hFFFF_FFFC, 3'b0, 2'd0, 1'b0);
    check("jal_wrap", bus.rf_wdata_o, 32'h0);
    issue(2'b11, 5'd31, 1'b1, 32'hDEAD_BEEF, 3'b0, 2'd0, 1'b0);
    issue(2'b00, 5'd0, 1'b1, 32'h0BAD_F00D, 3'b0, 2'd0, 1'b0);
    check("x0_no_we", bus.rf_we_o, 0);
    check("x0_retired", retired, 4);
    issue(2'b00, 5'd9, 1'b0, 32'h5555_AAAA, 3'b0, 2'd0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      r   = $urandom_range(0, 2);
      src = (r == 0) ? 2'b00 : (r == 1) ? 2'b10 : 2'b11;
      issue(src, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom, 3'b0, 2'd0, 1'b0);
    end

    issue(2'b01, 5'd4, 1'b1, 32'h0, 3'b000, 2'd3, 1'b1);
    mem_resp(32'h80AA_BBCC, 3);
    check("lb_wdata", bus.rf_wdata_o, 32'hFFFF_FF80);
    issue(2'b01, 5'd6, 1'b1, 32'h0, 3'b101, 2'd2, 1'b0);
    mem_resp(32'h80AA_BBCC, 0);
    check("lhu_wdata", bus.rf_wdata_o, 32'h0000_80AA);
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 6; i++) begin
        issue(2'b01, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 32'h0, lf3[i],
              2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        mem_resp($urandom, $urandom_range(0, 2));
      end
    end

    issue(2'b01, 5'd12, 1'b1, 32'h0, 3'b010, 2'd0, 1'b0);
    check("busy_before_rst", busy, 1);
    do_reset(1'b0);
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'hCAFE_BABE;
    @(negedge clk);
    bus.mem_rvalid_i = 1'b0;
    check("drop_rf_we", bus.rf_we_o, 0);
    check("drop_retired", retired, 0);
    check("drop_in_ready", bus.in_ready_o, 1);

    do_reset(1'b1);
    @(negedge clk);
    check("offer_rst_retired", retired, 0);
    check("offer_rst_busy", busy, 0);

    load64("ld64_lw", 3'b010, 3'd4, 64'h8000_0001_0000_0000, 64'hFFFF_FFFF_8000_0001);
    load64("ld64_lwu", 3'b110, 3'd4, 64'h8000_0001_0000_0000, 64'h0000_0000_8000_0001);
    load64("ld64_ld", 3'b011, 3'd5, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);
    load64("ld64_lb", 3'b000, 3'd7, 64'h80FF_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FF80);
    load64("ld64_lhu", 3'b101, 3'd5, 64'h1234_BEEF_5678_9ABC, 64'h0000_0000_0000_BEEF);
    load64("ld64_lw0", 3'b010, 3'd1, 64'h1234_BEEF_5678_9ABC, 64'h0000_0000_5678_9ABC);
    check("ret64_wrap", ret64, 2);

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    check("retired_final", retired, m_ret);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
